// File: rtl/ds_dac_mc.sv
// Multi-channel delta-sigma DAC modulator: double-buffered frame input, one
// first/second-order modulator per channel with saturating integrators.
module ds_dac_mc #(
    parameter int BW    = 14,
    parameter int CH    = 2,
    parameter int OSR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CH*BW-1:0] dac_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             order_i,
    input  logic [OSR_W-1:0] osr_i,
    output logic [CH-1:0]    dac_o,
    output logic             underrun_o
);

    localparam int IW   = BW + 3;  // integrator width
    localparam int SW   = BW + 5;  // headroom for i2 + i1 - fb before saturation
    localparam int FsI  = 2 ** (BW - 1);
    localparam int LimI = 2 ** (BW + 2) - 1;

    localparam logic signed [SW-1:0] Fs   = SW'(FsI);
    localparam logic signed [SW-1:0] Lim  = SW'(LimI);
    localparam logic signed [SW-1:0] NLim = -SW'(LimI);

    function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] r;
        if (v > Lim) begin
            r = Lim;
        end else if (v < NLim) begin
            r = NLim;
        end else begin
            r = v;
        end
        return IW'(r);
    endfunction

    logic [CH*BW-1:0]     shadow_q, shadow_d;
    logic [CH*BW-1:0]     active_q, active_d;
    logic                 full_q, full_d;
    logic [OSR_W-1:0]     cnt_q, cnt_d;
    logic                 order_q, order_d;
    logic [CH-1:0]        dac_q, dac_d;
    logic                 underrun_q, underrun_d;
    logic signed [IW-1:0] i1_q [CH];
    logic signed [IW-1:0] i1_d [CH];
    logic signed [IW-1:0] i2_q [CH];
    logic signed [IW-1:0] i2_d [CH];

    logic frame_end;
    logic clear;

    always_comb begin
        logic signed [SW-1:0] xs, fb, s1, s2;
        logic signed [IW-1:0] t1;
        logic                 d;

        frame_end = cnt_q >= osr_i;
        clear     = frame_end && (order_i != order_q);

        cnt_d      = frame_end ? '0 : cnt_q + 1'b1;
        order_d    = frame_end ? order_i : order_q;
        underrun_d = frame_end && !full_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        full_d     = full_q;

        // Transfer only when full and accept only when empty, so they never overlap.
        if (frame_end && full_q) begin
            active_d = shadow_q;
            full_d   = 1'b0;
        end
        if (valid_i && !full_q) begin
            shadow_d = dac_i;
            full_d   = 1'b1;
        end

        for (int k = 0; k < CH; k++) begin
            xs = SW'($signed(active_q[k*BW +: BW]));
            d  = order_q ? (i2_q[k] > 0) : (i1_q[k] > 0);
            fb = d ? Fs : -Fs;
            s1 = SW'(i1_q[k]) + xs - fb;
            t1 = sat(s1);
            s2 = SW'(i2_q[k]) + SW'(t1) - fb;
            dac_d[k] = d;
            i1_d[k]  = t1;
            i2_d[k]  = order_q ? sat(s2) : i2_q[k];
            if (clear) begin
                i1_d[k] = '0;
                i2_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q   <= '0;
            active_q   <= '0;
            full_q     <= 1'b0;
            cnt_q      <= '0;
            order_q    <= 1'b0;
            dac_q      <= '0;
            underrun_q <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                i1_q[k] <= '0;
                i2_q[k] <= '0;
            end
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            full_q     <= full_d;
            cnt_q      <= cnt_d;
            order_q    <= order_d;
            dac_q      <= dac_d;
            underrun_q <= underrun_d;
            for (int k = 0; k < CH; k++) begin
                i1_q[k] <= i1_d[k];
                i2_q[k] <= i2_d[k];
            end
        end
    end

    assign ready_o    = !full_q;
    assign dac_o      = dac_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_ds_dac_mc.sv
// Randomized bench for ds_dac_mc against an integer-arithmetic reference model
// of the buffering, framing and modulator equations.
module tb_ds_dac_mc;

    localparam int BW    = 14;
    localparam int CH    = 2;
    localparam int OSR_W = 8;
    localparam int FS    = 8192;
    localparam int LIM   = 65535;

    logic             clk = 1'b0;
    logic             rst_i = 1'b0;
    logic [CH*BW-1:0] dac_i = '0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic             order_i = 1'b0;
    logic [OSR_W-1:0] osr_i = '0;
    logic [CH-1:0]    dac_o;
    logic             underrun_o;

    ds_dac_mc #(.BW(BW), .CH(CH), .OSR_W(OSR_W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .dac_i     (dac_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .order_i   (order_i),
        .osr_i     (osr_i),
        .dac_o     (dac_o),
        .underrun_o(underrun_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int m_cnt, m_full, m_order, m_under;
    int m_sh[CH], m_act[CH], m_i1[CH], m_i2[CH], m_dac[CH];
    int ones[CH];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > LIM) ? LIM : ((v < -LIM) ? -LIM : v);
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_full = 0; m_order = 0; m_under = 0;
        for (int k = 0; k < CH; k++) begin
            m_sh[k] = 0; m_act[k] = 0; m_i1[k] = 0; m_i2[k] = 0; m_dac[k] = 0;
        end
    endtask

    // One clock of the reference model, from the inputs present before the edge.
    task automatic model_step();
        int fe, acc, d, fb, n1, n2;
        logic [BW-1:0] raw;
        fe  = (m_cnt >= int'(osr_i)) ? 1 : 0;
        acc = (valid_i && m_full == 0) ? 1 : 0;
        for (int k = 0; k < CH; k++) begin
            d  = (m_order == 0) ? (m_i1[k] > 0) : (m_i2[k] > 0);
            fb = d ? FS : -FS;
            n1 = sat(m_i1[k] + m_act[k] - fb);
            n2 = (m_order == 0) ? m_i2[k] : sat(m_i2[k] + n1 - fb);
            if (fe != 0 && int'(order_i) != m_order) begin
                n1 = 0;
                n2 = 0;
            end
            m_i1[k] = n1;
            m_i2[k] = n2;
            m_dac[k] = d;
        end
        m_under = (fe != 0 && m_full == 0) ? 1 : 0;
        if (fe != 0 && m_full != 0) begin
            for (int k = 0; k < CH; k++) m_act[k] = m_sh[k];
            m_full = 0;
        end
        if (acc != 0) begin
            for (int k = 0; k < CH; k++) begin
                raw = dac_i[k*BW +: BW];
                m_sh[k] = int'($signed(raw));
            end
            m_full = 1;
        end
        if (fe != 0) m_order = int'(order_i);
        m_cnt = (fe != 0) ? 0 : m_cnt + 1;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < CH; k++) begin
            check_eq($sformatf("dac%0d", k), int'(dac_o[k]), m_dac[k]);
            ones[k] += int'(dac_o[k]);
        end
        check_eq("ready", int'(ready_o), (m_full == 0) ? 1 : 0);
        check_eq("underrun", int'(underrun_o), m_under);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_x(input int x0, input int x1);
        int v;
        v = x0;
        dac_i[0 +: BW] = v[BW-1:0];
        v = x1;
        dac_i[BW +: BW] = v[BW-1:0];
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        check_eq("rst_dac", int'(dac_o), 0);
        check_eq("rst_ready", int'(ready_o), 1);
        check_eq("rst_underrun", int'(underrun_o), 0);
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic clear_ones();
        for (int k = 0; k < CH; k++) ones[k] = 0;
    endtask

    initial begin
        int lo, hi;
        clear_ones();
        model_reset();
        #2;
        do_reset();

        // x=0, every cycle a frame end: alternating output, underrun after transfer.
        osr_i = '0; order_i = 1'b0; set_x(0, 0); valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        steps(20);

        // First order at negative full scale: output never rises.
        do_reset();
        set_x(-8192, -8192); valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        steps(10);
        clear_ones();
        steps(256);
        check_eq("fo_negfs_ones", ones[0], 0);

        // First order just below positive full scale.
        do_reset();
        set_x(8191, 8191); valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        steps(2);
        clear_ones();
        steps(1024);
        check_eq("fo_posfs_ones", (ones[0] >= 1022) ? 1 : 0, 1);

        // Second order, +/-FS/2, long frames with continuous valid.
        do_reset();
        order_i = 1'b1; osr_i = 8'd255; set_x(4096, -4096); valid_i = 1'b1;
        steps(600);
        clear_ones();
        steps(4096);
        lo = 3072 - 41; hi = 3072 + 41;
        check_eq("so_dens0", (ones[0] >= lo && ones[0] <= hi) ? 1 : 0, 1);
        lo = 1024 - 41; hi = 1024 + 41;
        check_eq("so_dens1", (ones[1] >= lo && ones[1] <= hi) ? 1 : 0, 1);

        // Handshake with valid held high and 10-cycle frames.
        do_reset();
        order_i = 1'b0; osr_i = 8'd9; valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            set_x($urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192);
            step();
        end

        // Random traffic, order switches and frame-length changes.
        for (int i = 0; i < 3000; i++) begin
            valid_i = 1'($urandom_range(0, 1));
            dac_i   = (CH*BW)'($urandom);
            if ($urandom_range(0, 63) == 0) order_i = ~order_i;
            if ($urandom_range(0, 199) == 0) osr_i = OSR_W'($urandom_range(0, 15));
            step();
        end

        // Asynchronous reset mid-frame with a pending shadow sample.
        do_reset();
        order_i = 1'b0; osr_i = 8'd9; valid_i = 1'b1; set_x(5000, -3000);
        steps(3);
        valid_i = 1'b0;
        set_x(7000, 7000);
        steps(2);
        check_eq("pre_rst_full", int'(ready_o), 0);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("arst_dac", int'(dac_o), 0);
        check_eq("arst_ready", int'(ready_o), 1);
        check_eq("arst_underrun", int'(underrun_o), 0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        model_reset();
        check_eq("post_rst_ready", int'(ready_o), 1);
        steps(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
